user_id_sequencer: RTL and testbench
====================================

USER_ID_SEQUENCER -- requirements
Module: user_id_sequencer

Interface
REQ-001 Parameter NUM_WORDS, default 2, number of 32-bit ID words held; legal range 1..8.
REQ-002 Parameter USER_PROJECT_ID, default all-zero, width 32*NUM_WORDS, hardwired ID value; word k = bits [32k+31:32k].
REQ-003 Parameter SER_DIV, default 1, clock cycles per serial bit period; legal range 1..16.
REQ-004 One clock and one reset: reset is synchronous and active-high.
REQ-005 wb_clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 wb_rst_i  input  1  synchronous active-high reset.
REQ-007 rd_req  input  1  word read request, sampled each rising edge.
REQ-008 rd_addr  input  3  word index for read, sampled with rd_req.
REQ-009 rd_ack  output  1  one-cycle read completion pulse.
REQ-010 rd_data  output  32  read word, valid while rd_ack=1.
REQ-011 rd_err  output  1  read error flag, valid while rd_ack=1.
REQ-012 ser_start  input  1  request serial dump of all ID bits.
REQ-013 ser_out  output  1  current serial bit.
REQ-014 ser_strobe  output  1  high in last cycle of each bit period.
REQ-015 ser_busy  output  1  serial dump in progress.
REQ-016 ser_done  output  1  one-cycle pulse after final bit period.
REQ-017 mask_rev  output  32  registered copy of word 0.
REQ-018 id_checksum  output  32  XOR of all captured words.
REQ-019 id_valid  output  1  ID capture complete.

Function
REQ-020 FSM states LOAD, READY, SHIFT, DONE; reset enters LOAD with word index 0.
REQ-021 LOAD: each rising edge captures word[idx] from USER_PROJECT_ID into register file, XORs it into checksum, increments idx.
REQ-022 LOAD -> READY on the edge capturing idx=NUM_WORDS-1; id_valid=1 from that edge onward, i.e. NUM_WORDS edges after reset release.
REQ-023 mask_rev and id_checksum update as words are captured; final values stable once id_valid=1.
REQ-024 Read: rd_req=1 at edge N gives rd_ack=1 for exactly cycle N+1; rd_req held high yields ack every cycle.
REQ-025 rd_data = register word rd_addr, rd_err=0 when id_valid=1 and rd_addr<NUM_WORDS at sampling edge.
REQ-026 rd_addr>=NUM_WORDS or id_valid=0 at sampling: rd_ack=1, rd_err=1, rd_data=0.
REQ-027 rd_data and rd_err = 0 whenever rd_ack=0.
REQ-028 READY -> SHIFT on edge with ser_start=1; ser_start ignored in LOAD, SHIFT, DONE.
REQ-029 SHIFT order: word 0 first, each word MSB first, total 32*NUM_WORDS bits.
REQ-030 Each bit held on ser_out for exactly SER_DIV cycles; ser_strobe=1 only in the last cycle of each period.
REQ-031 ser_busy=1 exactly while in SHIFT.
REQ-032 After final bit period SHIFT -> DONE: ser_done=1 one cycle, then READY.
REQ-033 ser_out=0 outside SHIFT.
REQ-034 Read port operates independently of serial FSM; reads in SHIFT/DONE served per REQ-024..026.
REQ-035 Bit and divide counters sized for 256 bits and SER_DIV=16; no wrap within one dump.

Reset
REQ-036 wb_rst_i=1 at an edge: rd_ack, rd_err, rd_data, ser_out, ser_strobe, ser_busy, ser_done, id_valid, mask_rev, id_checksum, register file, all counters = 0; state=LOAD.
REQ-037 Reset asserted mid-SHIFT aborts the dump with no ser_done pulse; capture restarts per REQ-020.
REQ-038 rd_req and ser_start asserted during reset are ignored.

Verification
REQ-039 NUM_WORDS=2, ID=64'h12345678_9ABCDEF0, release reset -> id_valid=1 after 2 edges; mask_rev=32'h9ABCDEF0; id_checksum=32'h88888888.
REQ-040 Same config, rd_req rd_addr=1 -> next cycle rd_ack=1, rd_data=32'h12345678, rd_err=0; rd_addr=5 -> rd_ack=1, rd_err=1, rd_data=0.
REQ-041 rd_req in cycle right after reset release -> rd_ack=1, rd_err=1 (id_valid=0).
REQ-042 SER_DIV=3, ser_start in READY -> ser_busy 192 cycles, 64 strobes, bit stream 9ABCDEF0 then 12345678 MSB first, ser_done one pulse.
REQ-043 ser_start repeated during SHIFT -> ignored, dump length unchanged; rd_req during SHIFT served normally.
REQ-044 Reset at bit 20 of dump -> ser_busy=0 next cycle, no ser_done, id_valid=0 then re-asserts after NUM_WORDS edges.

Source files
------------

// File: rtl/user_id_sequencer_if.sv
// Bundle of the read port, serial dump port and ID status signals of user_id_sequencer.
// The master side issues reads and dump requests; the slave side is the sequencer.
interface user_id_sequencer_if;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        ser_start;
  logic        ser_out;
  logic        ser_strobe;
  logic        ser_busy;
  logic        ser_done;
  logic [31:0] mask_rev;
  logic [31:0] id_checksum;
  logic        id_valid;

  modport master (
    output rd_req, rd_addr, ser_start,
    input  rd_ack, rd_data, rd_err, ser_out, ser_strobe, ser_busy, ser_done,
    input  mask_rev, id_checksum, id_valid
  );

  modport slave (
    input  rd_req, rd_addr, ser_start,
    output rd_ack, rd_data, rd_err, ser_out, ser_strobe, ser_busy, ser_done,
    output mask_rev, id_checksum, id_valid
  );
endinterface

// File: rtl/user_id_sequencer.sv
// Captures a hardwired multi-word project ID into a register file, serves word reads,
// and dumps every ID bit serially (word 0 first, MSB first) at a programmable bit rate.
module user_id_sequencer #(
  parameter int                        NUM_WORDS       = 2,
  parameter logic [32*NUM_WORDS-1:0]   USER_PROJECT_ID = '0,
  parameter int                        SER_DIV         = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  user_id_sequencer_if.slave   bus
);

  localparam logic [8:0] LAST_BIT = 9'(32 * NUM_WORDS - 1);
  localparam logic [3:0] LAST_DIV = 4'(SER_DIV - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);
  localparam logic [3:0] NW       = 4'(NUM_WORDS);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [8:0]  bit_cnt;
  logic [3:0]  div_cnt;
  logic [31:0] regfile  [8];
  logic [31:0] id_words [8];
  logic [31:0] mask_q;
  logic [31:0] checksum_q;
  logic        id_valid_q;
  logic        rd_ack_q;
  logic        rd_err_q;
  logic [31:0] rd_data_q;
  logic        period_end;

  // Unused slots of the fixed 8-entry view read as zero so any 3-bit index is safe.
  for (genvar k = 0; k < 8; k++) begin : g_words
    if (k < NUM_WORDS) begin : g_used
      assign id_words[k] = USER_PROJECT_ID[32*k +: 32];
    end else begin : g_unused
      assign id_words[k] = '0;
    end
  end

  assign period_end = (div_cnt == LAST_DIV);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.ser_busy   = 1'b0;
    bus.ser_done   = 1'b0;
    bus.ser_strobe = 1'b0;
    bus.ser_out    = 1'b0;
    case (state)
      LOAD:  if (idx == LAST_IDX) state_nxt = READY;
      READY: if (bus.ser_start) state_nxt = SHIFT;
      SHIFT: begin
        bus.ser_busy   = 1'b1;
        bus.ser_strobe = period_end;
        bus.ser_out    = regfile[bit_cnt[7:5]][~bit_cnt[4:0]];
        if (period_end && (bit_cnt == LAST_BIT)) state_nxt = DONE;
      end
      DONE: begin
        bus.ser_done = 1'b1;
        state_nxt    = READY;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      idx        <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      mask_q     <= '0;
      checksum_q <= '0;
      id_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) regfile[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          regfile[idx] <= id_words[idx];
          checksum_q   <= checksum_q ^ id_words[idx];
          if (idx == 3'd0) mask_q <= id_words[0];
          if (idx == LAST_IDX) id_valid_q <= 1'b1;
          else                 idx        <= idx + 3'd1;
        end
        READY: begin
          bit_cnt <= '0;
          div_cnt <= '0;
        end
        SHIFT: begin
          if (period_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 9'd1;
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read port: one-cycle response, independent of the serial FSM.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= bus.rd_req;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
      if (bus.rd_req) begin
        if (id_valid_q && ({1'b0, bus.rd_addr} < NW)) rd_data_q <= regfile[bus.rd_addr];
        else                                          rd_err_q  <= 1'b1;
      end
    end
  end

  assign bus.rd_ack      = rd_ack_q;
  assign bus.rd_err      = rd_err_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.mask_rev    = mask_q;
  assign bus.id_checksum = checksum_q;
  assign bus.id_valid    = id_valid_q;

endmodule

// File: tb/tb_user_id_sequencer.sv
// Directed bench for user_id_sequencer: capture, reads, a full serial dump and a mid-dump reset.
module tb_user_id_sequencer;
  logic clk = 1'b0;
  logic rst;

  user_id_sequencer_if bus ();

  user_id_sequencer #(
    .NUM_WORDS      (2),
    .USER_PROJECT_ID(64'h12345678_9ABCDEF0),
    .SER_DIV        (3)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          cyc;
  int          busy_cnt;
  int          strobe_cnt;
  int          done_cnt;
  int          gap_bad;
  int          last_strobe;
  int          idle_out_bad;
  logic [63:0] stream;

  initial begin
    rst           = 1'b1;
    bus.rd_req    = 1'b1;
    bus.rd_addr   = 3'd0;
    bus.ser_start = 1'b1;
    repeat (3) step();

    // Requests during reset are ignored and everything is cleared.
    check("rst_rd_ack",   bus.rd_ack, 0);
    check("rst_rd_err",   bus.rd_err, 0);
    check("rst_id_valid", bus.id_valid, 0);
    check("rst_mask",     bus.mask_rev, 0);
    check("rst_checksum", bus.id_checksum, 0);
    check("rst_busy",     bus.ser_busy, 0);
    check("rst_ser_out",  bus.ser_out, 0);

    // Read in the first cycle after release hits id_valid=0.
    rst           = 1'b0;
    bus.ser_start = 1'b0;
    step();
    check("early_rd_ack",  bus.rd_ack, 1);
    check("early_rd_err",  bus.rd_err, 1);
    check("early_rd_data", bus.rd_data, 0);
    check("load1_valid",   bus.id_valid, 0);
    check("load1_mask",    bus.mask_rev, 32'h9ABCDEF0);
    bus.rd_req = 1'b0;
    step();
    check("load2_valid",    bus.id_valid, 1);
    check("load2_checksum", bus.id_checksum, 32'h88888888);
    check("load2_mask",     bus.mask_rev, 32'h9ABCDEF0);
    check("idle_rd_ack",    bus.rd_ack, 0);
    check("idle_rd_err",    bus.rd_err, 0);
    check("idle_rd_data",   bus.rd_data, 0);

    // Back-to-back reads with rd_req held high.
    bus.rd_req  = 1'b1;
    bus.rd_addr = 3'd1;
    step();
    check("rd1_ack",  bus.rd_ack, 1);
    check("rd1_data", bus.rd_data, 32'h12345678);
    check("rd1_err",  bus.rd_err, 0);
    bus.rd_addr = 3'd5;
    step();
    check("rd5_ack",  bus.rd_ack, 1);
    check("rd5_err",  bus.rd_err, 1);
    check("rd5_data", bus.rd_data, 0);
    bus.rd_addr = 3'd0;
    step();
    check("rd0_data", bus.rd_data, 32'h9ABCDEF0);
    check("rd0_err",  bus.rd_err, 0);
    bus.rd_req = 1'b0;
    step();
    check("rd_end_ack",  bus.rd_ack, 0);
    check("rd_end_data", bus.rd_data, 0);

    // Full serial dump, with a repeated start and a read in the middle.
    bus.ser_start = 1'b1;
    step();
    bus.ser_start = 1'b0;
    cyc = 0; busy_cnt = 0; strobe_cnt = 0; done_cnt = 0; gap_bad = 0;
    idle_out_bad = 0; last_strobe = -1; stream = '0;
    while (done_cnt == 0 && cyc < 400) begin
      if (bus.ser_busy) busy_cnt++;
      else if (bus.ser_out !== 1'b0 || bus.ser_strobe !== 1'b0) idle_out_bad++;
      if (bus.ser_strobe) begin
        strobe_cnt++;
        stream = {stream[62:0], bus.ser_out};
        if (cyc - last_strobe != 3) gap_bad++;
        last_strobe = cyc;
      end
      if (bus.ser_done) done_cnt++;
      if (cyc == 11) begin
        check("shift_rd_ack",  bus.rd_ack, 1);
        check("shift_rd_data", bus.rd_data, 32'h12345678);
      end
      bus.ser_start = (cyc == 10);
      bus.rd_req    = (cyc == 10);
      bus.rd_addr   = 3'd1;
      if (done_cnt == 0) begin
        step();
        cyc++;
      end
    end
    check("dump_done_seen", done_cnt, 1);
    check("dump_busy_cycles", busy_cnt, 192);
    check("dump_strobes", strobe_cnt, 64);
    check("dump_stream", stream, 64'h9ABCDEF0_12345678);
    check("dump_strobe_gap", gap_bad, 0);
    check("dump_idle_out", idle_out_bad, 0);
    check("done_busy", bus.ser_busy, 0);
    step();
    check("done_one_pulse", bus.ser_done, 0);
    check("after_done_busy", bus.ser_busy, 0);

    // Second dump, reset asserted once bit 20 is on the line.
    bus.ser_start = 1'b1;
    step();
    bus.ser_start = 1'b0;
    strobe_cnt = 0; cyc = 0;
    while (strobe_cnt < 20 && cyc < 200) begin
      if (bus.ser_strobe) strobe_cnt++;
      step();
      cyc++;
    end
    check("abort_reached_bit20", strobe_cnt, 20);
    check("abort_busy_before", bus.ser_busy, 1);
    rst = 1'b1;
    step();
    check("abort_busy",     bus.ser_busy, 0);
    check("abort_done",     bus.ser_done, 0);
    check("abort_valid",    bus.id_valid, 0);
    check("abort_ser_out",  bus.ser_out, 0);
    check("abort_checksum", bus.id_checksum, 0);
    check("abort_mask",     bus.mask_rev, 0);

    // Recapture; a start request during LOAD must be ignored.
    rst           = 1'b0;
    bus.ser_start = 1'b1;
    step();
    check("recap1_valid", bus.id_valid, 0);
    check("recap1_done",  bus.ser_done, 0);
    bus.ser_start = 1'b0;
    step();
    check("recap2_valid",    bus.id_valid, 1);
    check("recap2_checksum", bus.id_checksum, 32'h88888888);
    step();
    check("load_start_ignored", bus.ser_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
